// File: rtl/vs_pace_gen_if.sv
// Pacing generator bus: rate request in, sync pulse and status out.
// The master side drives enable and the BCD digits; the slave is the generator.
interface vs_pace_gen_if;
    logic       enable;
    logic [3:0] fps_h;
    logic [3:0] fps_l;
    logic       vs;
    logic       sec_tick;
    logic [6:0] rate_q;
    logic       cfg_err;

    modport master (
        output enable,
        output fps_h,
        output fps_l,
        input  vs,
        input  sec_tick,
        input  rate_q,
        input  cfg_err
    );

    modport slave (
        input  enable,
        input  fps_h,
        input  fps_l,
        output vs,
        output sec_tick,
        output rate_q,
        output cfg_err
    );
endinterface

// File: rtl/vs_pace_gen.sv
// Vertical-sync pacing generator: N evenly spread vs pulses per second,
// placed by a phase accumulator, so no divider is needed.
module vs_pace_gen #(
    parameter int ONE_SEC  = 50_000_000,
    parameter int VS_WIDTH = 16
) (
    input  logic         clk50,
    input  logic         reset,
    vs_pace_gen_if.slave bus
);

    localparam logic [26:0] SEC_LAST = 27'(ONE_SEC - 1);
    localparam logic [26:0] SEC_LEN  = 27'(ONE_SEC);
    localparam int          WW       = (VS_WIDTH > 1) ? $clog2(VS_WIDTH) : 1;
    localparam logic [WW-1:0] W_LOAD = WW'(VS_WIDTH - 1);

    typedef enum logic {
        IDLE,
        HIGH
    } state_t;

    logic [26:0]   sec_cnt;
    logic [26:0]   acc;
    logic [26:0]   acc_sum;
    logic [26:0]   acc_next;
    logic [26:0]   rate_ext;
    logic [6:0]    rate_q;
    logic [6:0]    bcd_val;
    logic          cfg_err;
    logic          bcd_ok;
    logic          boundary;
    logic          fire;
    state_t        state;
    state_t        state_n;
    logic [WW-1:0] wcnt;
    logic [WW-1:0] wcnt_n;

    assign boundary = (sec_cnt == SEC_LAST);
    assign bcd_ok   = (bus.fps_h <= 4'd9) && (bus.fps_l <= 4'd9);
    assign bcd_val  = 7'(bus.fps_h) * 7'd10 + 7'(bus.fps_l);

    // acc tracks (sec_cnt * rate) mod ONE_SEC; it drops below rate
    // exactly once per 1/rate of a second.
    assign rate_ext = {20'd0, rate_q};
    assign acc_sum  = acc + rate_ext;
    assign acc_next = (acc_sum >= SEC_LEN) ? acc_sum - SEC_LEN : acc_sum;
    assign fire     = bus.enable && (acc < rate_ext) && !reset;

    always_ff @(posedge clk50) begin
        if (reset) begin
            sec_cnt <= '0;
            acc     <= '0;
        end else if (boundary) begin
            sec_cnt <= '0;
            acc     <= '0;
        end else begin
            sec_cnt <= sec_cnt + 27'd1;
            acc     <= acc_next;
        end
    end

    // Rate is only sampled at window edges so one window never mixes rates.
    always_ff @(posedge clk50) begin
        if (reset || boundary) begin
            if (bcd_ok) begin
                rate_q  <= bcd_val;
                cfg_err <= 1'b0;
            end else begin
                cfg_err <= 1'b1;
                if (reset) begin
                    rate_q <= '0;
                end
            end
        end
    end

    always_ff @(posedge clk50) begin
        if (reset) begin
            state <= IDLE;
            wcnt  <= '0;
        end else begin
            state <= state_n;
            wcnt  <= wcnt_n;
        end
    end

    // A fire arriving while HIGH is dropped; pulses never retrigger.
    always_comb begin
        state_n = state;
        wcnt_n  = wcnt;
        unique case (state)
            IDLE: begin
                if (fire) begin
                    state_n = HIGH;
                    wcnt_n  = W_LOAD;
                end
            end
            HIGH: begin
                if (wcnt == '0) begin
                    state_n = IDLE;
                end else begin
                    wcnt_n = wcnt - WW'(1);
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign bus.vs       = (state == HIGH);
    assign bus.sec_tick = boundary;
    assign bus.rate_q   = rate_q;
    assign bus.cfg_err  = cfg_err;

endmodule

// File: tb/tb_vs_pace_gen.sv
// Bench for vs_pace_gen: reset table, directed pacing scenarios and
// random traffic, all scored against a window-level reference model.
module tb_vs_pace_gen;

    localparam int N = 1000;
    localparam int W = 4;

    logic clk50 = 1'b0;
    logic reset;

    vs_pace_gen_if bus ();

    vs_pace_gen #(
        .ONE_SEC (N),
        .VS_WIDTH(W)
    ) dut (
        .clk50(clk50),
        .reset(reset),
        .bus  (bus)
    );

    always #10 clk50 = ~clk50;

    int total = 0;
    int bad   = 0;

    int m_sec     = 0;
    int m_rate    = 0;
    int m_vs_left = 0;
    bit m_err     = 1'b0;

    bit prev_vs = 1'b0;
    int rises[$];
    int ticks = 0;

    typedef struct {
        logic [3:0] h;
        logic [3:0] l;
        int         rate;
        bit         err;
    } rst_vec_t;

    rst_vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at sec %0d: got %0d want %0d",
                     name, m_sec, act, exp);
        end
    endtask

    // Fire instants of a window: ceil(j*N/r) for j = 0..r-1.
    function automatic bit is_fire(int k, int r);
        for (int j = 0; j < r; j++) begin
            if (k == (j * N + r - 1) / r) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic step();
        int n_sec, n_rate, n_left, val;
        bit n_err, f, ok;
        ok  = (bus.fps_h <= 4'd9) && (bus.fps_l <= 4'd9);
        val = int'(bus.fps_h) * 10 + int'(bus.fps_l);
        if (reset) begin
            n_sec  = 0;
            n_left = 0;
            n_rate = ok ? val : 0;
            n_err  = !ok;
        end else begin
            f = bus.enable && (m_rate > 0) && is_fire(m_sec, m_rate);
            n_left = (m_vs_left > 0) ? m_vs_left - 1 : (f ? W : 0);
            if (m_sec == N - 1) begin
                n_sec  = 0;
                n_rate = ok ? val : m_rate;
                n_err  = !ok;
            end else begin
                n_sec  = m_sec + 1;
                n_rate = m_rate;
                n_err  = m_err;
            end
        end
        @(posedge clk50);
        #1;
        m_sec     = n_sec;
        m_rate    = n_rate;
        m_err     = n_err;
        m_vs_left = n_left;
        check("vs", bus.vs, (m_vs_left > 0));
        check("sec_tick", bus.sec_tick, (m_sec == N - 1));
        check("rate_q", bus.rate_q, m_rate);
        check("cfg_err", bus.cfg_err, m_err);
        if (bus.vs === 1'b1 && !prev_vs) rises.push_back(m_sec);
        if (bus.sec_tick === 1'b1) ticks++;
        prev_vs = (bus.vs === 1'b1);
    endtask

    task automatic to_sec(input int s);
        for (int i = 0; i < 2 * N && m_sec != s; i++) step();
        check("reach_sec", m_sec, s);
    endtask

    task automatic set_bcd(input logic [3:0] h, input logic [3:0] l);
        bus.fps_h = h;
        bus.fps_l = l;
    endtask

    task automatic window();
        rises.delete();
        repeat (N) step();
    endtask

    initial begin
        int p7[7];
        int mn, mx, d;
        p7 = '{1, 144, 287, 430, 573, 716, 859};

        vecs[0] = '{4'd2, 4'd5, 25, 1'b0};
        vecs[1] = '{4'd0, 4'd7, 7, 1'b0};
        vecs[2] = '{4'd9, 4'd9, 99, 1'b0};
        vecs[3] = '{4'hA, 4'd3, 0, 1'b1};
        vecs[4] = '{4'd0, 4'd0, 0, 1'b0};
        vecs[5] = '{4'd3, 4'hF, 0, 1'b1};
        vecs[6] = '{4'd1, 4'd0, 10, 1'b0};

        bus.enable = 1'b1;
        reset      = 1'b1;
        set_bcd(4'd0, 4'd0);

        foreach (vecs[i]) begin
            set_bcd(vecs[i].h, vecs[i].l);
            reset = 1'b1;
            step();
            check("tbl_rate", bus.rate_q, vecs[i].rate);
            check("tbl_err", bus.cfg_err, vecs[i].err);
            check("tbl_vs", bus.vs, 0);
            check("tbl_tick", bus.sec_tick, 0);
        end

        // exact spacing at 25 fps
        set_bcd(4'd2, 4'd5);
        step();
        reset = 1'b0;
        check("rel_sec0_rate", bus.rate_q, 25);
        for (int w = 0; w < 3; w++) begin
            window();
            check("cnt25", rises.size(), 25);
            if (rises.size() == 25)
                for (int i = 0; i < 25; i++) check("pos25", rises[i], 40 * i + 1);
        end

        // uneven division at 7 fps
        set_bcd(4'd0, 4'd7);
        window();
        check("cnt25_pre7", rises.size(), 25);
        check("rate7", bus.rate_q, 7);
        for (int w = 0; w < 2; w++) begin
            window();
            check("cnt7", rises.size(), 7);
            if (rises.size() == 7)
                for (int i = 0; i < 7; i++) check("pos7", rises[i], p7[i]);
        end

        // mid-second change ignored until boundary
        set_bcd(4'd2, 4'd5);
        window();
        rises.delete();
        to_sec(500);
        set_bcd(4'd9, 4'd9);
        to_sec(N - 1);
        check("mid_tick", bus.sec_tick, 1);
        check("mid_rate_hold", bus.rate_q, 25);
        step();
        check("mid_rate99", bus.rate_q, 99);
        check("mid_cnt25", rises.size(), 25);
        window();
        check("cnt99", rises.size(), 99);
        mn = 1000;
        mx = 0;
        for (int i = 1; i < rises.size(); i++) begin
            d = rises[i] - rises[i-1];
            if (d < mn) mn = d;
            if (d > mx) mx = d;
        end
        check("gap99_min", mn, 10);
        check("gap99_max", mx, 11);

        // invalid BCD keeps the old rate
        set_bcd(4'd2, 4'd5);
        window();
        set_bcd(4'hA, 4'd3);
        window();
        check("bad_err", bus.cfg_err, 1);
        check("bad_rate", bus.rate_q, 25);
        set_bcd(4'd1, 4'd0);
        window();
        check("bad_cnt25", rises.size(), 25);
        check("fix_err", bus.cfg_err, 0);
        check("fix_rate", bus.rate_q, 10);
        window();
        check("cnt10", rises.size(), 10);

        // enable gating keeps phase
        set_bcd(4'd2, 4'd5);
        window();
        rises.delete();
        to_sec(42);
        bus.enable = 1'b0;
        to_sec(46);
        check("en_vs46", bus.vs, 0);
        to_sec(500);
        check("en_gated_cnt", rises.size(), 2);
        bus.enable = 1'b1;
        rises.delete();
        to_sec(600);
        check("en_cnt", rises.size(), 2);
        if (rises.size() == 2) begin
            check("en_rise521", rises[0], 521);
            check("en_rise561", rises[1], 561);
        end
        to_sec(0);

        // zero rate, then reset in the middle of a pulse
        set_bcd(4'd0, 4'd0);
        window();
        ticks = 0;
        window();
        repeat (N) step();
        check("zero_rises", rises.size(), 0);
        check("zero_ticks", ticks, 2);
        set_bcd(4'd2, 4'd5);
        window();
        to_sec(43);
        check("pre_rst_vs", bus.vs, 1);
        reset = 1'b1;
        step();
        check("rst_mid_vs", bus.vs, 0);
        step();
        reset = 1'b0;
        rises.delete();
        step();
        check("rst_rise_cnt", rises.size(), 1);
        if (rises.size() == 1) check("rst_rise_sec1", rises[0], 1);

        // random traffic against the model
        for (int i = 0; i < 12 * N; i++) begin
            if ($urandom_range(49) == 0) bus.enable = ~bus.enable;
            if ($urandom_range(299) == 0) begin
                if ($urandom_range(3) == 0)
                    set_bcd(4'($urandom_range(15)), 4'($urandom_range(15)));
                else
                    set_bcd(4'($urandom_range(9)), 4'($urandom_range(9)));
            end
            reset = ($urandom_range(2999) == 0);
            step();
        end
        reset = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vs_pace_gen.md
# vs_pace_gen

Programmable vertical-sync pacing generator. It emits `vs` pulses at an exact integer rate of 0–99 frames per second on the 50 MHz fabric clock. The rate is given as two BCD digits. The block drives the frame-rate measurement path and camera-less bring-up benches, distributing exactly N rising edges evenly across every one-second window. It uses a phase accumulator and needs no divider.

## Interface
- `ONE_SEC`, 50_000_000: clk50 cycles per second window. Must be at most 2^26. Sim uses 1000.
- `VS_WIDTH`, 16: vs high time in cycles, 1 ≤ VS_WIDTH ≤ ONE_SEC/99 − 1.
- `clk50` in 1: sole clock, 50 MHz.
- `reset` in 1: synchronous, active-high.
- `enable` in 1: when low, no new pulses start.
- `fps_h` in 4: requested rate, tens digit (BCD).
- `fps_l` in 4: requested rate, units digit (BCD).
- `vs` out 1: generated vertical sync, registered.
- `sec_tick` out 1: one-cycle pulse in the last cycle of each second window.
- `rate_q` out 7: active rate in binary, 0–99.
- `cfg_err` out 1: sticky-per-second flag, set when a load rejected a non-BCD digit.

## Operation
- **Second counter** `sec_cnt` (27 b):
  - Runs 0..ONE_SEC−1 and wraps to 0.
  - It always runs, independent of `enable`.
  - "Boundary" means the cycle where `sec_cnt == ONE_SEC−1`.
- **Rate load** at each boundary, and on every cycle while `reset` is high:
  - If `fps_h ≤ 9` and `fps_l ≤ 9`: `rate_q <= fps_h*10 + fps_l` and `cfg_err <= 0`.
  - Otherwise: `rate_q` holds (forced to 0 if in reset) and `cfg_err <= 1`.
  - The inputs are sampled only at these points. Changes mid-second are ignored.
- **Phase accumulator** `acc` (27 b), holding `acc == (sec_cnt*rate_q) mod ONE_SEC`:
  - Each cycle: `acc_next = acc + rate_q`, minus ONE_SEC if the sum is ≥ ONE_SEC.
  - At a boundary: `acc <= 0`.
- **Fire condition**: `fire = enable && (acc < rate_q) && !reset`.
  - Fires occur at `sec_cnt = ceil(j*ONE_SEC/rate_q)` for j = 0..rate_q−1, exactly rate_q fires per window.
  - `rate_q = 0` never fires.
- **Pulse FSM**, states IDLE and HIGH:
  - IDLE --fire--> HIGH: load width counter with VS_WIDTH−1, set `vs = 1`.
  - HIGH: decrement the counter. At 0, go to IDLE with `vs = 0`.
  - A fire while in HIGH cannot occur within the legal VS_WIDTH range. If it occurs anyway, it is ignored (no retrigger).
- **`enable` deassert**: a pulse already in progress completes. Accumulator and second counter keep running, so re-enabling keeps phase alignment.
- **Arithmetic widths**: `rate_q` is 7 b, zero-extended to 27 b. `acc + rate_q < 2^27` always holds, so there is no overflow.

## Timing
- **Reset values**: `vs=0`, `sec_tick=0`, `cfg_err=0` unless BCD is invalid during reset, `rate_q` = valid BCD value or 0, `sec_cnt=0`, `acc=0`, FSM = IDLE.
- **First cycle after reset release**: `sec_cnt = 0` and `acc = 0`. A nonzero rate fires in this cycle.
- **vs latency**: `vs` rises one cycle after the fire cycle.
  - The fire at `sec_cnt = k` gives `vs = 1` while `sec_cnt` runs k+1 .. k+VS_WIDTH.
  - The first rising edge of each window is therefore at `sec_cnt = 1`, never at `sec_cnt = 0`.
- **sec_tick**: asserted in the cycle where `sec_cnt == ONE_SEC−1`. A new `rate_q` is visible from the next cycle (`sec_cnt = 0`).
- **Reset mid-pulse**: `vs` drops in the next cycle and the FSM returns to IDLE.

## Test plan
- **Exact spacing**: ONE_SEC=1000, VS_WIDTH=4, BCD 2/5, reset then run 3 windows.
  - Required: vs rises at `sec_cnt` 1, 41, 81, … 961, i.e. 25 rising edges per window, each high for exactly 4 cycles.
- **Uneven division**: BCD 0/7.
  - Required: rises at `sec_cnt` 1, 144, 287, 430, 573, 716, 859; 7 per window; identical in every window.
- **Mid-second change and boundary load**: running at 25, switch inputs to 9/9 at `sec_cnt = 500`.
  - Required: remainder of the window stays at 25 edges.
  - Required: `rate_q = 99` from the cycle after `sec_tick`.
  - Required: next window has 99 edges, spacing 10–11 cycles, no overlap.
- **Invalid BCD**: rate 25, then present A/3 across a boundary.
  - Required: `cfg_err = 1`, `rate_q` stays 25, still 25 edges.
  - Restoring 1/0 gives `cfg_err = 0`, `rate_q = 10`, 10 edges next window.
- **Enable gating**: rate 25, drop `enable` at `sec_cnt = 42` (mid-pulse), raise it at 500.
  - Required: the current pulse completes (vs low at 46); no rises in 42..500.
  - Required: the next rise is at 521, and subsequent rises stay on the 40-cycle grid.
- **Zero rate and reset mid-pulse**: BCD 0/0 gives no vs for 2 windows and `sec_tick` every 1000 cycles.
  - At rate 25, assert reset at `sec_cnt = 43`: required `vs = 0` on the next cycle; after release, vs rises at `sec_cnt = 1`.
